// File: rtl/lt_coarse_counter_mc.sv
// ---------------------------------------------------------------------------
// lt_coarse_counter_mc
//
// Coarse time counter for the TDC path. The count is split into carry
// segments of SEG_W bits. Each segment only sees a short local increment,
// and the "all lower segments are all-ones" condition comes from registered
// lookahead flags. This keeps every carry path to one segment plus a small
// AND of flags, and the count is still an exact binary count of cnt_en
// cycles. It also provides a sticky wrap flag, a synchronous clear, and
// N_CH independent stop-capture channels with a valid/ack handshake.
//
// Parameters:
//   CNT_W  counter width in bits (>=2)
//   SEG_W  carry segment width (1..CNT_W); the top segment may be narrower
//   N_CH   number of stop-capture channels (>=1)
//
// Ports:
//   clk5      in   counter clock
//   rst       in   asynchronous active-high reset
//   cnt_en    in   count enable, +1 per high cycle
//   clr       in   synchronous clear of counter and ovf (wins over cnt_en)
//   stop      in   [N_CH]  per-channel capture strobe, level sampled
//   cap_ack   in   [N_CH]  per-channel consumer acknowledge
//   counter   out  [CNT_W] current count
//   ovf       out  sticky wrap flag
//   cap_data  out  [N_CH*(CNT_W+1)] channel i at [i*(CNT_W+1) +: CNT_W+1],
//                  MSB = ovf, remaining bits = counter
//   cap_vld   out  [N_CH]  channel holds unread data
//   miss      out  [N_CH]  sticky: a stop was dropped on a full channel
// ---------------------------------------------------------------------------
module lt_coarse_counter_mc #(
    parameter int CNT_W = 14,
    parameter int SEG_W = 4,
    parameter int N_CH  = 4
) (
    input  logic                       clk5,
    input  logic                       rst,
    input  logic                       cnt_en,
    input  logic                       clr,
    input  logic [N_CH-1:0]            stop,
    input  logic [N_CH-1:0]            cap_ack,
    output logic [CNT_W-1:0]           counter,
    output logic                       ovf,
    output logic [N_CH*(CNT_W+1)-1:0]  cap_data,
    output logic [N_CH-1:0]            cap_vld,
    output logic [N_CH-1:0]            miss
);

    localparam int NSEG = (CNT_W + SEG_W - 1) / SEG_W;
    localparam int DW   = CNT_W + 1;

    logic [CNT_W-1:0]      counter_q;
    logic [CNT_W-1:0]      counter_d;
    logic [CNT_W-1:0]      countInc;
    logic [NSEG-1:0]       allOnes_q;
    logic [NSEG-1:0]       allOnes_d;
    logic [NSEG-1:0]       segCarry;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  wrap;
    logic [N_CH*DW-1:0]    capData_q;
    logic [N_CH*DW-1:0]    capData_d;
    logic [N_CH-1:0]       capVld_q;
    logic [N_CH-1:0]       capVld_d;
    logic [N_CH-1:0]       miss_q;
    logic [N_CH-1:0]       miss_d;

    // Per-segment increment. A segment advances when the count is enabled
    // and every lower segment is all-ones. The all-ones information comes
    // from allOnes_q, which is registered, so no carry ripples across
    // segments. allOnes_d recomputes the flags from the next-state value.
    // That keeps allOnes_q an exact description of counter_q every cycle,
    // including after clr. A zero count gives all flags low, which matches
    // the reset value of the flags.
    for (genvar k = 0; k < NSEG; k++) begin : gSeg
        localparam int LO = k * SEG_W;
        localparam int W  = ((CNT_W - LO) < SEG_W) ? (CNT_W - LO) : SEG_W;

        if (k == 0) begin : gFirst
            assign segCarry[k] = cnt_en;
        end else begin : gUpper
            assign segCarry[k] = cnt_en & (&allOnes_q[k-1:0]);
        end

        assign countInc[LO +: W] = counter_q[LO +: W] + W'(segCarry[k]);
        assign allOnes_d[k]      = &counter_d[LO +: W];
    end

    // The whole counter wraps exactly when it is enabled while every
    // segment is all-ones.
    assign wrap = cnt_en & (&allOnes_q);

    // Counter and overflow next state. clr discards any count in the same
    // cycle, and it also drops the sticky wrap flag.
    always_comb begin
        counter_d = countInc;
        ovf_d     = ovf_q | wrap;
        if (clr) begin
            counter_d = '0;
            ovf_d     = 1'b0;
        end
    end

    // Capture channels. Each channel samples {ovf, counter} from the
    // pre-edge registers, so a stop coinciding with clr sees the old value.
    // A stop is accepted when the slot is empty or is being acknowledged in
    // the same cycle. Otherwise it is dropped and flagged in miss. An ack on
    // an empty channel has no effect.
    always_comb begin
        capData_d = capData_q;
        capVld_d  = capVld_q;
        miss_d    = miss_q;
        for (int i = 0; i < N_CH; i++) begin
            if (stop[i]) begin
                if (!capVld_q[i] || cap_ack[i]) begin
                    capData_d[i*DW +: DW] = {ovf_q, counter_q};
                    capVld_d[i]           = 1'b1;
                end else begin
                    miss_d[i] = 1'b1;
                end
            end else if (cap_ack[i]) begin
                capVld_d[i] = 1'b0;
            end
        end
    end

    // State registers. Everything returns to zero as soon as rst rises.
    always_ff @(posedge clk5 or posedge rst) begin
        if (rst) begin
            counter_q <= '0;
            allOnes_q <= '0;
            ovf_q     <= 1'b0;
            capData_q <= '0;
            capVld_q  <= '0;
            miss_q    <= '0;
        end else begin
            counter_q <= counter_d;
            allOnes_q <= allOnes_d;
            ovf_q     <= ovf_d;
            capData_q <= capData_d;
            capVld_q  <= capVld_d;
            miss_q    <= miss_d;
        end
    end

    assign counter  = counter_q;
    assign ovf      = ovf_q;
    assign cap_data = capData_q;
    assign cap_vld  = capVld_q;
    assign miss     = miss_q;

endmodule

// File: tb/tb_lt_coarse_counter_mc.sv
// ---------------------------------------------------------------------------
// tb_lt_coarse_counter_mc
//
// Directed bench for lt_coarse_counter_mc with its default parameters
// (CNT_W=14, SEG_W=4, N_CH=4). Inputs change on the falling edge, and the
// outputs are sampled on the following falling edge. A small count/ovf
// reference follows the applied enables and clears. Capture expectations
// are written out by hand.
// ---------------------------------------------------------------------------
module tb_lt_coarse_counter_mc;

    localparam int CNT_W = 14;
    localparam int SEG_W = 4;
    localparam int N_CH  = 4;
    localparam int DW    = CNT_W + 1;

    logic                    clk5;
    logic                    rst;
    logic                    cnt_en;
    logic                    clr;
    logic [N_CH-1:0]         stop;
    logic [N_CH-1:0]         cap_ack;
    logic [CNT_W-1:0]        counter;
    logic                    ovf;
    logic [N_CH*DW-1:0]      cap_data;
    logic [N_CH-1:0]         cap_vld;
    logic [N_CH-1:0]         miss;

    logic [CNT_W-1:0]        expCnt;
    logic                    expOvf;
    int                      checks;
    int                      fails;

    lt_coarse_counter_mc #(
        .CNT_W (CNT_W),
        .SEG_W (SEG_W),
        .N_CH  (N_CH)
    ) dut (
        .clk5     (clk5),
        .rst      (rst),
        .cnt_en   (cnt_en),
        .clr      (clr),
        .stop     (stop),
        .cap_ack  (cap_ack),
        .counter  (counter),
        .ovf      (ovf),
        .cap_data (cap_data),
        .cap_vld  (cap_vld),
        .miss     (miss)
    );

    // 10-unit clock period
    initial begin
        clk5 = 1'b0;
        forever #5 clk5 = ~clk5;
    end

    // Extract one capture channel from the packed bus
    function automatic logic [DW-1:0] chData(input int ch);
        return cap_data[ch*DW +: DW];
    endfunction

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance to the next
    // falling edge. The count reference is updated from the same inputs.
    task automatic applyStimulus(input logic en, input logic clrIn,
                                 input logic [N_CH-1:0] stopIn,
                                 input logic [N_CH-1:0] ackIn);
        cnt_en  = en;
        clr     = clrIn;
        stop    = stopIn;
        cap_ack = ackIn;
        if (clrIn) begin
            expCnt = '0;
            expOvf = 1'b0;
        end else if (en) begin
            if (expCnt == {CNT_W{1'b1}}) expOvf = 1'b1;
            expCnt = expCnt + 1'b1;
        end
        @(posedge clk5);
        @(negedge clk5);
        cnt_en  = 1'b0;
        clr     = 1'b0;
        stop    = '0;
        cap_ack = '0;
    endtask

    // Run n plain cycles with a fixed enable and no capture activity
    task automatic runCycles(input int n, input logic en);
        for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, '0, '0);
    endtask

    // Directed sequence
    initial begin
        logic [CNT_W-1:0] altA [8];
        logic [CNT_W-1:0] altB [8];

        altA = '{14'h0FF, 14'h0FF, 14'h100, 14'h100, 14'h101, 14'h101, 14'h102, 14'h102};
        altB = '{14'hFFF, 14'hFFF, 14'h1000, 14'h1000, 14'h1001, 14'h1001, 14'h1002, 14'h1002};

        checks  = 0;
        fails   = 0;
        expCnt  = '0;
        expOvf  = 1'b0;
        rst     = 1'b1;
        cnt_en  = 1'b0;
        clr     = 1'b0;
        stop    = '0;
        cap_ack = '0;

        // Reset state
        @(negedge clk5);
        @(negedge clk5);
        checkOutput("rst_counter", 32'(counter), 32'h0);
        checkOutput("rst_ovf", 32'(ovf), 32'h0);
        checkOutput("rst_cap_data", 32'(cap_data != '0), 32'h0);
        checkOutput("rst_cap_vld", 32'(cap_vld), 32'h0);
        checkOutput("rst_miss", 32'(miss), 32'h0);
        rst = 1'b0;

        // 20 enabled cycles, one increment per edge
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0);
            checkOutput("t1_count", 32'(counter), 32'(i));
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("t1_hold20", 32'(counter), 32'h14);
        checkOutput("t1_ovf", 32'(ovf), 32'h0);

        // Toggling enable across the 0x0FF->0x100 boundary
        runCycles(14'h0FE - 14'd20, 1'b1);
        checkOutput("t2_at_0FE", 32'(counter), 32'h0FE);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(((i % 2) == 0), 1'b0, '0, '0);
            checkOutput("t2_alt_100", 32'(counter), 32'(altA[i]));
        end

        // Toggling enable across the 0xFFF->0x1000 boundary
        runCycles(14'h0FFE - 14'h102, 1'b1);
        checkOutput("t2_at_FFE", 32'(counter), 32'hFFE);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(((i % 2) == 0), 1'b0, '0, '0);
            checkOutput("t2_alt_1000", 32'(counter), 32'(altB[i]));
        end

        // Full wrap from zero with every intermediate value checked
        applyStimulus(1'b0, 1'b1, '0, '0);
        checkOutput("t3_clr", 32'(counter), 32'h0);
        for (int i = 0; i < 16384; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0);
            checkOutput("t3_wrap_cnt", 32'(counter), 32'(expCnt));
            checkOutput("t3_wrap_ovf", 32'(ovf), 32'(expOvf));
        end
        checkOutput("t3_wrapped", 32'(counter), 32'h0);
        checkOutput("t3_ovf_set", 32'(ovf), 32'h1);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("t3_after_wrap", 32'(counter), 32'h1);
        checkOutput("t3_ovf_sticky", 32'(ovf), 32'h1);
        applyStimulus(1'b1, 1'b1, '0, '0);
        checkOutput("t3_clr_cnt", 32'(counter), 32'h0);
        checkOutput("t3_clr_ovf", 32'(ovf), 32'h0);

        // Capture on channel 2, then a dropped capture, then an ack
        runCycles(14'h123, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000);
        checkOutput("t4_vld", 32'(cap_vld), 32'b0100);
        checkOutput("t4_data", 32'(chData(2)), 32'h0123);
        checkOutput("t4_cnt", 32'(counter), 32'h124);
        runCycles(14'h130 - 14'h124, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000);
        checkOutput("t4_keep_data", 32'(chData(2)), 32'h0123);
        checkOutput("t4_miss", 32'(miss), 32'b0100);
        checkOutput("t4_vld_full", 32'(cap_vld), 32'b0100);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0100);
        checkOutput("t4_ack_vld", 32'(cap_vld), 32'b0000);
        checkOutput("t4_miss_sticky", 32'(miss), 32'b0100);

        // Channel 1 refill: stop and ack together on a full channel
        runCycles(14'h1F0 - 14'h131, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0000);
        checkOutput("t5_fill_data", 32'(chData(1)), 32'h01F0);
        runCycles(14'h200 - 14'h1F1, 1'b1);
        checkOutput("t5_at_200", 32'(counter), 32'h200);
        applyStimulus(1'b1, 1'b0, 4'b0010, 4'b0010);
        checkOutput("t5_vld", 32'(cap_vld), 32'b0010);
        checkOutput("t5_data", 32'(chData(1)), 32'h0200);
        checkOutput("t5_miss", 32'(miss), 32'b0100);

        // Wrap again to reach 0x3FF with ovf set, then stop[0] together with clr
        runCycles(16384 - 32'h201 + 32'h3FF, 1'b1);
        checkOutput("t5_at_3FF", 32'(counter), 32'h3FF);
        checkOutput("t5_ovf", 32'(ovf), 32'h1);
        applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000);
        checkOutput("t5_clr_cap", 32'(chData(0)), 32'h43FF);
        checkOutput("t5_clr_cnt", 32'(counter), 32'h0);
        checkOutput("t5_clr_ovf", 32'(ovf), 32'h0);
        checkOutput("t5_ch1_kept", 32'(chData(1)), 32'h0200);
        checkOutput("t5_vld2", 32'(cap_vld), 32'b0011);

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1'b0, 1'b0, 4'b1000, 4'b0001);
        checkOutput("t6_vld_setup", 32'(cap_vld), 32'b1010);
        runCycles(14'h1A5, 1'b1);
        checkOutput("t6_at_1A5", 32'(counter), 32'h1A5);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_async_cnt", 32'(counter), 32'h0);
        checkOutput("t6_async_ovf", 32'(ovf), 32'h0);
        checkOutput("t6_async_data", 32'(cap_data != '0), 32'h0);
        checkOutput("t6_async_vld", 32'(cap_vld), 32'h0);
        checkOutput("t6_async_miss", 32'(miss), 32'h0);
        @(negedge clk5);
        rst    = 1'b0;
        expCnt = '0;
        expOvf = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0);
            checkOutput("t6_recount", 32'(counter), 32'(expCnt));
        end
        checkOutput("t6_final", 32'(counter), 32'h14);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
